// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_chunk_adder
//  Purpose  : Multi-cycle add/subtract, DIGIT bits per clock, LSB chunk first,
//             with carry-out and signed/unsigned overflow reporting.
//  Revision : 1.0  initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int c_ncyc  = WIDTH / DIGIT;
    localparam int c_cnt_w = (c_ncyc > 1) ? $clog2(c_ncyc) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_ncyc - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_chunk_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic               r_sub;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;
    logic [DIGIT:0]     w_c;
    logic [DIGIT-1:0]   w_s;
    logic [WIDTH-1:0]   w_res_next;

    assign w_accept = start && (r_state == c_idle || r_state == c_done);
    assign w_last   = (r_state == c_run) && (r_cnt == c_last);

    // Operands shift right each chunk, so the chain always reads the low DIGIT bits.
    assign w_c[0] = r_carry;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fa
            assign w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
            assign w_c[i+1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
        end
        if (WIDTH == DIGIT) begin : g_res_single
            assign w_res_next = w_s;
        end else begin : g_res_shift
            assign w_res_next = {w_s, r_res[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = c_idle;
        case (r_state)
            c_idle:  w_state_next = start ? c_run : c_idle;
            c_run:   w_state_next = w_last ? c_done : c_run;
            c_done:  w_state_next = start ? c_run : c_idle;
            default: w_state_next = c_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_run:   busy = 1'b1;
            c_done:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_sub   <= sub;
            r_cnt   <= '0;
        end else if (r_state == c_run) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_res   <= w_res_next;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                // w_c[DIGIT-1] is the carry into bit WIDTH-1 on the final chunk.
                sum  <= w_res_next;
                cout <= w_c[DIGIT];
                ovf  <= SIGNED ? (w_c[DIGIT-1] ^ w_c[DIGIT]) : (w_c[DIGIT] ^ r_sub);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Multi-cycle, parametrised add/subtract unit for operands up to WIDTH bits.
- Processes DIGIT bits per clock, LSB chunk first, through a DIGIT-bit ripple chain of full-adder cells. A registered carry links each chunk to the next.
- Used in area-constrained tiles where a full-width adder is too large. Accepts one operation per start/done handshake.
- Reports carry-out plus signed or unsigned overflow.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0, elaboration error otherwise.
- SIGNED, 1, 1 = ovf reports two's-complement overflow; 0 = ovf reports unsigned carry/borrow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin (cin acts as borrow-in).
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- cin  input  1  carry-in (add) or borrow-in (sub), captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; sum/cout/ovf are valid from this cycle.
- sum  output  WIDTH  result.
- cout  output  1  raw final carry out of bit WIDTH-1.
- ovf  output  1  overflow flag, per SIGNED.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset state:
  - state = IDLE.
  - busy, done, sum, cout, ovf = 0.
  - Internal operand/shift/carry registers = 0.
- NCYC = WIDTH/DIGIT.
- States:
  - IDLE -> RUN on start=1.
  - RUN: NCYC cycles.
  - DONE: 1 cycle, then -> IDLE, or directly -> RUN if start=1 in that cycle.
- Accept: start=1 at a rising edge while state is IDLE or DONE.
  - Latch a.
  - Latch b_eff = sub ? ~b : b.
  - Set carry register = cin ^ sub.
  - Reset chunk counter to 0.
  - busy=1 from the next cycle.
- RUN, per edge:
  - chunk k = bits [k*DIGIT +: DIGIT] of a and b_eff, plus the carry register, through the DIGIT-bit full-adder chain.
  - The chunk result shifts into the internal result register from the top, so after NCYC edges the result is LSB-aligned.
  - carry register <= chunk carry-out.
  - Counter increments.
- Last chunk (k = NCYC-1):
  - Also capture the carry into bit WIDTH-1 (c_msb).
  - Next state = DONE.
  - busy<=0, done<=1.
  - sum <= assembled result.
  - cout <= final carry.
  - ovf <= SIGNED ? (c_msb ^ final carry) : (final carry ^ sub).
- Latency: done is high in the NCYC+1-th cycle after the accepting edge (WIDTH=8, DIGIT=1: 9 cycles).
- Output hold: sum/cout/ovf change only at completion. They hold their values through IDLE and through a following RUN until the next completion. done is high for exactly one cycle.
- start while busy=1 (RUN): ignored. It has no effect on operands or timing, and no queuing.
- Back-to-back: start=1 in the DONE cycle is accepted. The next done follows NCYC+1 cycles later with no idle gap.
- Input changes on a/b/sub/cin after accept have no effect on the operation in progress.
- rst_n low mid-operation: immediate clear to the reset state. No done is produced for the aborted operation.
- WIDTH=DIGIT: NCYC=1. done appears 2 cycles after accept.

Test Plan:
- WIDTH=8, DIGIT=1, SIGNED=1: a=0x5A, b=0x33, sub=0, cin=0 -> done 9 cycles after accept; sum=0x8D, cout=0, ovf=1.
- WIDTH=8, DIGIT=1, SIGNED=1, sub=1:
  - a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1.
  - a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0, ovf=0.
  - Repeat the second case with SIGNED=0 -> ovf=1 (borrow).
- WIDTH=8, DIGIT=4: a=0xFF, b=0x01, cin=1, sub=0 -> done 3 cycles after accept; sum=0x01, cout=1, ovf=0 (SIGNED=1).
- Busy collision and back-to-back (WIDTH=8, DIGIT=1):
  - Pulse start with new operands during RUN -> ignored; result matches the first operation.
  - Assert start in the DONE cycle with a=0x01, b=0x01 -> accepted; second done exactly 9 cycles later, sum=0x02.
- Reset: assert rst_n=0 asynchronously at RUN cycle 4 -> busy, done, sum, cout, ovf = 0 immediately, with no done pulse afterwards. After release, a new operation with a=0x7F, b=0x01 completes normally -> sum=0x80, ovf=1.
- Hold: after completion, toggle a/b/cin for 20 cycles with start=0 -> sum/cout/ovf unchanged, done stays 0.
